// File: rtl/sdio_cmd_uart_logger_if.sv
`default_nettype none
// ============================================================================
//  Module   : sdio_cmd_uart_logger_if
//  Purpose  : Bundles the SDIO command-receive inputs, the uart_tx byte
//             handshake and the logger status outputs into one port.
//  Revision : 1.0  initial release
// ============================================================================
interface sdio_cmd_uart_logger_if #(
  parameter int DEPTH = 16
);
  logic [37:0]            cmd_data;
  logic                   cmd_strobe;
  logic                   cmd_error;
  logic                   enable;
  logic                   clear_overflow;
  logic                   uart_tx_send_byte;
  logic [7:0]             uart_tx_byte;
  logic                   uart_tx_active;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;

  // Environment side: produces commands, models uart_tx, watches status
  modport master (
    output cmd_data, cmd_strobe, cmd_error, enable, clear_overflow, uart_tx_active,
    input  uart_tx_send_byte, uart_tx_byte, fifo_count, overflow
  );

  // Logger side
  modport slave (
    input  cmd_data, cmd_strobe, cmd_error, enable, clear_overflow, uart_tx_active,
    output uart_tx_send_byte, uart_tx_byte, fifo_count, overflow
  );
endinterface
`default_nettype wire

// File: rtl/sdio_cmd_uart_logger.sv
`default_nettype none
// ============================================================================
//  Module   : sdio_cmd_uart_logger
//  Purpose  : Buffers received SDIO command words in a FIFO and serialises
//             each as a 6-byte frame {SYNC, {err,lost,cmd[37:32]}, cmd[31:0]}
//             onto the uart_tx byte interface.
//  Revision : 1.0  initial release
// ============================================================================
module sdio_cmd_uart_logger #(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  wire                    clock,
  input  wire                    reset_n,
  sdio_cmd_uart_logger_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_SEND       = 3'd2,
    S_WAIT_START = 3'd3,
    S_WAIT_DONE  = 3'd4
  } state_t;

  logic [38:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic          r_ovf;
  logic          r_lost;

  state_t        r_state;
  logic [2:0]    r_idx;
  logic [38:0]   r_sh;
  logic          r_lost_cap;
  logic          r_send;
  logic [7:0]    r_byte;

  logic [PW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_req;
  logic          w_push;
  logic          w_drop;
  logic [2:0]    w_nidx;
  logic [7:0]    w_next_byte;

  // Pointers carry one extra bit so full and empty are distinguishable
  assign w_count = r_wr - r_rd;
  assign w_full  = (w_count == PW'(DEPTH));
  assign w_empty = (w_count == '0);
  // LOAD is only entered with a non-empty FIFO, so it always pops
  assign w_pop   = (r_state == S_LOAD);
  assign w_req   = bus.cmd_strobe & bus.enable;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept
  assign w_push  = w_req & (~w_full | w_pop);
  assign w_drop  = w_req & w_full & ~w_pop;
  assign w_nidx  = r_idx + 3'd1;

  // Select the frame byte that follows the one currently on the wire
  always_comb begin
    w_next_byte = SYNC_BYTE;
    case (w_nidx)
      3'd1:    w_next_byte = {r_sh[38], r_lost_cap, r_sh[37:32]};
      3'd2:    w_next_byte = r_sh[31:24];
      3'd3:    w_next_byte = r_sh[23:16];
      3'd4:    w_next_byte = r_sh[15:8];
      3'd5:    w_next_byte = r_sh[7:0];
      default: w_next_byte = SYNC_BYTE;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy is pointer-based
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr[AW-1:0]] <= {bus.cmd_error, bus.cmd_data};
    end
  end

  // FIFO pointers plus sticky overflow and the lost-word marker
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_ovf  <= 1'b0;
      r_lost <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      // A drop in the same cycle as a clear keeps the flag set
      if (w_drop)                  r_ovf <= 1'b1;
      else if (bus.clear_overflow) r_ovf <= 1'b0;
      // The marker is consumed by the frame being loaded unless a new drop lands
      if (w_drop)     r_lost <= 1'b1;
      else if (w_pop) r_lost <= 1'b0;
    end
  end

  // Frame serialiser: one byte per uart_tx start/finish handshake
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_idx      <= 3'd0;
      r_sh       <= '0;
      r_lost_cap <= 1'b0;
      r_send     <= 1'b0;
      r_byte     <= 8'h00;
    end else begin
      r_send <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_empty) r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_sh       <= r_mem[r_rd[AW-1:0]];
          r_lost_cap <= r_lost;
          r_idx      <= 3'd0;
          r_byte     <= SYNC_BYTE;
          r_send     <= 1'b1;
          r_state    <= S_SEND;
        end
        S_SEND: begin
          r_state <= S_WAIT_START;
        end
        S_WAIT_START: begin
          if (bus.uart_tx_active) r_state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (!bus.uart_tx_active) begin
            if (r_idx == 3'd5) begin
              r_state <= S_IDLE;
            end else begin
              r_idx   <= w_nidx;
              r_byte  <= w_next_byte;
              r_send  <= 1'b1;
              r_state <= S_SEND;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.uart_tx_send_byte = r_send;
  assign bus.uart_tx_byte      = r_byte;
  assign bus.fifo_count        = w_count;
  assign bus.overflow          = r_ovf;

endmodule
`default_nettype wire
